// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//   Byte-stream boot loader sitting in front of the cpu top. A frame is a
//   command byte, optionally followed by a little-endian 16-bit word count and
//   that many words, LSB byte first. Load commands fill instruction memory
//   (32-bit words) or data memory (64-bit words) through the cpu external
//   write ports. The run command raises cpu_enable until a stop command.
//
// Ports
//   clk          main clock, rising edge
//   arst_n       asynchronous reset, active low
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     byte accepted this cycle when in_valid is also high
//   imem_addr    instruction write byte address  (cpu addr_ext)
//   imem_wen     instruction write strobe         (cpu wen_ext)
//   imem_wdata   instruction write data           (cpu wdata_ext)
//   dmem_addr    data write byte address          (cpu addr_ext_2)
//   dmem_wen     data write strobe                (cpu wen_ext_2)
//   dmem_wdata   data write data                  (cpu wdata_ext_2)
//   cpu_enable   cpu run enable
//   busy         a frame is being parsed or a word is being written
//   done         one-cycle pulse when a load frame completes
//   err          sticky protocol error, cleared only by reset
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a command byte
//   S_CNT_LO | waiting for word count bits [7:0]
//   S_CNT_HI | waiting for word count bits [15:8]
//   S_DATA   | assembling the current word, one byte per transfer
//   S_WRITE  | write strobe is out, stream stalled, pointer advances
//   S_RUN    | cpu enabled, only the stop command is legal

module cpu_program_loader #(
  parameter logic [63:0] IMEM_BASE = 64'h0,
  parameter logic [63:0] DMEM_BASE = 64'h0,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_wen,
  output logic [63:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;
  localparam logic [7:0] CMD_STOP = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic             tgt_dmem_q;
  logic [2:0]       byte_idx_q;
  logic [63:0]      asm_q;
  logic [7:0]       cnt_lo_q;
  logic [CNT_W-1:0] words_left_q;
  logic [63:0]      imem_ptr_q;
  logic [63:0]      dmem_ptr_q;

  logic [63:0]      imem_addr_q;
  logic [31:0]      imem_wdata_q;
  logic             imem_wen_q;
  logic [63:0]      dmem_addr_q;
  logic [63:0]      dmem_wdata_q;
  logic             dmem_wen_q;
  logic             done_q;
  logic             err_q;

  logic             xfer;
  logic             last_byte;
  logic             last_word;
  logic [63:0]      asm_next;
  logic [CNT_W-1:0] count_full;
  logic             load_cmd;
  logic             err_set;

  assign in_ready   = (state_q != S_WRITE);
  assign xfer       = in_valid & in_ready;
  assign cpu_enable = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE) && (state_q != S_RUN);

  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign imem_wen   = imem_wen_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wen   = dmem_wen_q;
  assign done       = done_q;
  assign err        = err_q;

  assign last_byte  = tgt_dmem_q ? (byte_idx_q == 3'd7) : (byte_idx_q == 3'd3);
  assign last_word  = (words_left_q == CNT_W'(1));
  assign count_full = CNT_W'({in_data, cnt_lo_q});
  assign load_cmd   = (in_data == CMD_IMEM) || (in_data == CMD_DMEM);

  // Word being assembled with the current byte merged in, so the write
  // registers can capture the complete word on the last byte's transfer.
  always_comb begin
    asm_next = asm_q;
    asm_next[{byte_idx_q, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (load_cmd) begin
            state_d = S_CNT_LO;
          end else if (in_data == CMD_RUN) begin
            state_d = S_RUN;
          end else if (in_data != CMD_STOP) begin
            err_set = 1'b1;
          end
        end
      end
      S_CNT_LO: begin
        if (xfer) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (xfer) state_d = (count_full == '0) ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (xfer && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = last_word ? S_IDLE : S_DATA;
      end
      S_RUN: begin
        if (xfer) begin
          if (in_data == CMD_STOP) begin
            state_d = S_IDLE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write port registers are loaded on the last byte's transfer so the
  // strobe lands in S_WRITE; the pointer only advances in S_WRITE, which
  // leaves addr/wdata showing the last written word while the strobe is low.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tgt_dmem_q   <= 1'b0;
      byte_idx_q   <= 3'd0;
      asm_q        <= 64'd0;
      cnt_lo_q     <= 8'd0;
      words_left_q <= '0;
      imem_ptr_q   <= IMEM_BASE;
      dmem_ptr_q   <= DMEM_BASE;
      imem_addr_q  <= IMEM_BASE;
      imem_wdata_q <= 32'd0;
      imem_wen_q   <= 1'b0;
      dmem_addr_q  <= DMEM_BASE;
      dmem_wdata_q <= 64'd0;
      dmem_wen_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_wen_q <= 1'b0;
      dmem_wen_q <= 1'b0;
      done_q     <= 1'b0;
      if (err_set) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (xfer && load_cmd) begin
            tgt_dmem_q <= (in_data == CMD_DMEM);
            byte_idx_q <= 3'd0;
            asm_q      <= 64'd0;
            if (in_data == CMD_DMEM) begin
              dmem_ptr_q <= DMEM_BASE;
            end else begin
              imem_ptr_q <= IMEM_BASE;
            end
          end
        end
        S_CNT_LO: begin
          if (xfer) cnt_lo_q <= in_data;
        end
        S_CNT_HI: begin
          if (xfer) begin
            words_left_q <= count_full;
            if (count_full == '0) done_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            asm_q      <= asm_next;
            byte_idx_q <= byte_idx_q + 3'd1;
            if (last_byte) begin
              byte_idx_q <= 3'd0;
              if (last_word) done_q <= 1'b1;
              if (tgt_dmem_q) begin
                dmem_wen_q   <= 1'b1;
                dmem_addr_q  <= dmem_ptr_q;
                dmem_wdata_q <= asm_next;
              end else begin
                imem_wen_q   <= 1'b1;
                imem_addr_q  <= imem_ptr_q;
                imem_wdata_q <= asm_next[31:0];
              end
            end
          end
        end
        S_WRITE: begin
          words_left_q <= words_left_q - CNT_W'(1);
          asm_q        <= 64'd0;
          if (tgt_dmem_q) begin
            dmem_ptr_q <= dmem_ptr_q + 64'd8;
          end else begin
            imem_ptr_q <= imem_ptr_q + 64'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
module tb_cpu_program_loader;

  localparam logic [63:0] IB = 64'h0000_0000_0000_1000;
  localparam logic [63:0] DB = 64'hFFFF_FFFF_FFFF_FFF0;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        err;

  cpu_program_loader #(.IMEM_BASE(IB), .DMEM_BASE(DB), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_wdata(imem_wdata), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_wdata(dmem_wdata), .cpu_enable(cpu_enable), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // kind: 0 = imem write, 1 = dmem write, 2 = done without a write
  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] data;
    bit          done;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] last_idata = '0;
  logic [63:0] last_iaddr = '0;
  logic [63:0] last_ddata = '0;
  logic [63:0] last_daddr = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Expected write/done events of a whole frame, derived from the frame layout.
  task automatic model_frame(input byte unsigned f[$]);
    int n, bpw;
    logic [63:0] base, d;
    ev_t e;
    if (f.size() == 0) return;
    if (f[0] == 8'h01 || f[0] == 8'h02) begin
      bpw  = (f[0] == 8'h01) ? 4 : 8;
      base = (f[0] == 8'h01) ? IB : DB;
      n    = int'(f[1]) | (int'(f[2]) << 8);
      if (n == 0) begin
        e.kind = 2; e.addr = '0; e.data = '0; e.done = 1'b1;
        exp_q.push_back(e);
      end
      for (int w = 0; w < n; w++) begin
        d = '0;
        for (int k = 0; k < bpw; k++) d |= 64'(f[3 + w * bpw + k]) << (8 * k);
        e.kind = (f[0] == 8'h01) ? 0 : 1;
        e.addr = base + 64'(bpw * w);
        e.data = d;
        e.done = (w == n - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called and returns at a falling edge.
  task automatic send(input byte unsigned b, input int gap);
    int tries;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    tries = 0;
    while (!in_ready && tries < 10) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready %b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input byte unsigned f[$], input int maxgap);
    foreach (f[i]) send(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pending_events", exp_q.size(), 0);
  endtask

  task automatic run_frame(input byte unsigned f[$], input int maxgap);
    model_frame(f);
    drive_frame(f, maxgap);
    wait_drain();
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (mon_en && arst_n === 1'b1) begin
      if (imem_wen || dmem_wen) begin
        chk("wen_both_memories", {63'd0, imem_wen & dmem_wen}, 64'd0);
        chk("in_ready_during_write", {63'd0, in_ready}, 64'd0);
      end
      if (imem_wen || dmem_wen || done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event imem_wen %b dmem_wen %b done %b required none",
                   imem_wen, dmem_wen, done);
        end else begin
          e = exp_q.pop_front();
          kind = imem_wen ? 0 : (dmem_wen ? 1 : 2);
          chk("event_kind", 64'(kind), 64'(e.kind));
          chk("done_with_event", {63'd0, done}, {63'd0, e.done});
          if (kind == 0) begin
            chk("imem_addr", imem_addr, e.addr);
            chk("imem_wdata", {32'd0, imem_wdata}, {32'd0, e.data[31:0]});
            last_idata = imem_wdata;
            last_iaddr = imem_addr;
          end else if (kind == 1) begin
            chk("dmem_addr", dmem_addr, e.addr);
            chk("dmem_wdata", dmem_wdata, e.data);
            last_ddata = dmem_wdata;
            last_daddr = dmem_addr;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    byte unsigned f[$];
    arst_n   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_in_ready",   {63'd0, in_ready},   64'd1);
    chk("rst_imem_wen",   {63'd0, imem_wen},   64'd0);
    chk("rst_dmem_wen",   {63'd0, dmem_wen},   64'd0);
    chk("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
    chk("rst_busy",       {63'd0, busy},       64'd0);
    chk("rst_done",       {63'd0, done},       64'd0);
    chk("rst_err",        {63'd0, err},        64'd0);
    chk("rst_imem_addr",  imem_addr, IB);
    chk("rst_dmem_addr",  dmem_addr, DB);
    arst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // IMEM load of two words, back to back
    f = '{8'h01, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    model_frame(f);
    chk("pin_model_w0_data", exp_q[0].data, 64'h13);
    chk("pin_model_w1_addr", exp_q[1].addr, 64'h1004);
    drive_frame(f, 0);
    wait_drain();
    chk("t1_last_idata", {32'd0, last_idata}, 64'h0010_0093);
    chk("t1_last_iaddr", last_iaddr, 64'h1004);
    chk("t1_busy_idle", {63'd0, busy}, 64'd0);

    // DMEM load of one word
    f = '{8'h02, 8'h01, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    run_frame(f, 0);
    chk("t2_last_ddata", last_ddata, 64'h0123_4567_89AB_CDEF);
    chk("t2_last_daddr", last_daddr, 64'hFFFF_FFFF_FFFF_FFF0);

    // DMEM load of three words crossing the 64-bit address wrap, with gaps
    f = '{8'h02, 8'h03, 8'h00};
    for (int i = 0; i < 24; i++) f.push_back(8'(8'h30 + i));
    run_frame(f, 2);
    chk("t2b_wrap_daddr", last_daddr, 64'h0);
    chk("t2b_wrap_ddata", last_ddata, 64'h4746_4544_4342_4140);

    // zero count frame: done only, addr/wdata hold the last write
    f = '{8'h01, 8'h00, 8'h00};
    run_frame(f, 0);
    chk("t4_imem_addr_hold",  imem_addr, 64'h1004);
    chk("t4_imem_wdata_hold", {32'd0, imem_wdata}, 64'h0010_0093);
    chk("t4_err_clear", {63'd0, err}, 64'd0);

    // IMEM load again with random stalls
    f = '{8'h01, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame(f, 3);
    chk("t5_last_idata", {32'd0, last_idata}, 64'h0010_0093);
    chk("t5_err_clear", {63'd0, err}, 64'd0);

    // run / stop, then a bad command in IDLE
    send(8'h03, 0);
    chk("t3_enable_on", {63'd0, cpu_enable}, 64'd1);
    chk("t3_busy_run",  {63'd0, busy}, 64'd0);
    send(8'h04, 0);
    chk("t3_enable_off", {63'd0, cpu_enable}, 64'd0);
    chk("t3_err_after_stop", {63'd0, err}, 64'd0);
    send(8'h7F, 0);
    chk("t4_bad_cmd_err", {63'd0, err}, 64'd1);
    f = '{8'h01, 8'h00, 8'h00};
    run_frame(f, 0);
    chk("t4_err_sticky", {63'd0, err}, 64'd1);

    // reset in the middle of a data word
    f = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB};
    drive_frame(f, 0);
    mon_en = 1'b0;
    arst_n = 1'b0;
    #2;
    chk("t6_rst_err",       {63'd0, err},       64'd0);
    chk("t6_rst_busy",      {63'd0, busy},      64'd0);
    chk("t6_rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("t6_rst_imem_addr", imem_addr, IB);
    chk("t6_rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    f = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(f, 1);
    chk("t6_reload_idata", {32'd0, last_idata}, 64'h4433_2211);
    chk("t6_reload_iaddr", last_iaddr, 64'h1000);

    // illegal byte while running
    send(8'h03, 0);
    chk("t3b_enable_on", {63'd0, cpu_enable}, 64'd1);
    send(8'hFF, 0);
    chk("t3b_err_in_run", {63'd0, err}, 64'd1);
    chk("t3b_enable_stays", {63'd0, cpu_enable}, 64'd1);
    send(8'h04, 0);
    chk("t3b_enable_off", {63'd0, cpu_enable}, 64'd0);
    repeat (3) @(negedge clk);
    chk("final_no_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
